mcdt_formatter: RTL

- Downstream packet formatter for the mcdt arbiter output.
- Accepts the single-word stream `mcdt_data/mcdt_val/mcdt_id` (no backpressure available) into three per-channel FIFOs.
- Emits fixed-length packets per channel to the downstream consumer under a req/grant handshake, with round-robin fairness between channels.

---
 rtl/mcdt_formatter.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/mcdt_formatter.sv
// Buffers the mcdt word stream in three per-channel FIFOs and emits fixed-length
// packets per channel under a req/grant handshake with round-robin fairness.
module mcdt_formatter #(
  parameter int unsigned DW         = 32,
  parameter int unsigned FIFO_DEPTH = 32
) (
  input  logic          clk_i,
  input  logic          rstn_i,
  input  logic [DW-1:0] mcdt_data_i,
  input  logic          mcdt_val_i,
  input  logic [1:0]    mcdt_id_i,
  input  logic [1:0]    pkt_len_i,
  input  logic          ovf_clr_i,
  output logic          fmt_req_o,
  input  logic          fmt_grant_i,
  output logic [1:0]    fmt_chid_o,
  output logic [5:0]    fmt_length_o,
  output logic          fmt_val_o,
  output logic [DW-1:0] fmt_data_o,
  output logic          fmt_start_o,
  output logic          fmt_end_o,
  output logic [2:0]    ovf_o
);
  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW-1:0] Full = CntW'(FIFO_DEPTH);

  typedef enum logic [1:0] {StIdle, StReq, StSend} state_e;

  state_e          state_q, state_d;
  logic [DW-1:0]   mem_q [3][FIFO_DEPTH];
  logic [PtrW-1:0] wptr_q [3];
  logic [PtrW-1:0] wptr_d [3];
  logic [PtrW-1:0] rptr_q [3];
  logic [PtrW-1:0] rptr_d [3];
  logic [CntW-1:0] cnt_q [3];
  logic [CntW-1:0] cnt_d [3];
  logic [2:0]      push, pop, ovf_set, ovf_q, ovf_d;
  logic [3:0]      elig;
  logic [1:0]      rr_q, rr_d, chid_q, chid_d, cand1, cand2, pick;
  logic            found;
  logic [5:0]      len_sel, len_q, len_d, wcnt_q, wcnt_d;
  logic            req_q, req_d, val_q, val_d, start_q, start_d, end_q, end_d;
  logic [DW-1:0]   data_q, data_d, rd_data;

  function automatic logic [1:0] next_ch(input logic [1:0] c);
    return (c == 2'd2) ? 2'd0 : c + 2'd1;
  endfunction

  always_comb begin
    len_sel = 6'd4 << pkt_len_i;
    rd_data = '0;
    elig    = '0;
    for (int c = 0; c < 3; c++) begin
      // A full FIFO drops the write even if it is being popped this cycle.
      ovf_set[c] = mcdt_val_i && (mcdt_id_i == 2'(c)) && (cnt_q[c] == Full);
      push[c]    = mcdt_val_i && (mcdt_id_i == 2'(c)) && (cnt_q[c] != Full);
      pop[c]     = (state_q == StSend) && (chid_q == 2'(c));
      wptr_d[c]  = push[c] ? wptr_q[c] + PtrW'(1) : wptr_q[c];
      rptr_d[c]  = pop[c] ? rptr_q[c] + PtrW'(1) : rptr_q[c];
      case ({push[c], pop[c]})
        2'b10:   cnt_d[c] = cnt_q[c] + CntW'(1);
        2'b01:   cnt_d[c] = cnt_q[c] - CntW'(1);
        default: cnt_d[c] = cnt_q[c];
      endcase
      elig[c] = 32'(cnt_q[c]) >= 32'(len_sel);
      if (chid_q == 2'(c)) rd_data = mem_q[c][rptr_q[c]];
    end
    ovf_d = ovf_set | (ovf_q & ~{3{ovf_clr_i}});
  end

  always_comb begin
    cand1 = next_ch(rr_q);
    cand2 = next_ch(cand1);
    found = 1'b1;
    pick  = rr_q;
    if (elig[rr_q])       pick = rr_q;
    else if (elig[cand1]) pick = cand1;
    else if (elig[cand2]) pick = cand2;
    else                  found = 1'b0;
  end

  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    chid_d  = chid_q;
    len_d   = len_q;
    wcnt_d  = wcnt_q;
    req_d   = req_q;
    val_d   = 1'b0;
    start_d = 1'b0;
    end_d   = 1'b0;
    data_d  = data_q;
    unique case (state_q)
      StIdle: begin
        if (found) begin
          chid_d  = pick;
          len_d   = len_sel;
          req_d   = 1'b1;
          state_d = StReq;
        end
      end
      StReq: begin
        if (fmt_grant_i) begin
          req_d   = 1'b0;
          wcnt_d  = '0;
          state_d = StSend;
        end
      end
      StSend: begin
        val_d   = 1'b1;
        data_d  = rd_data;
        start_d = (wcnt_q == 6'd0);
        end_d   = (wcnt_q == len_q - 6'd1);
        wcnt_d  = wcnt_q + 6'd1;
        if (end_d) begin
          state_d = StIdle;
          rr_d    = next_ch(chid_q);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    for (int c = 0; c < 3; c++) begin
      if (push[c]) mem_q[c][wptr_q[c]] <= mcdt_data_i;
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q <= StIdle;
      for (int c = 0; c < 3; c++) begin
        wptr_q[c] <= '0;
        rptr_q[c] <= '0;
        cnt_q[c]  <= '0;
      end
      ovf_q   <= '0;
      rr_q    <= '0;
      chid_q  <= '0;
      len_q   <= '0;
      wcnt_q  <= '0;
      req_q   <= 1'b0;
      val_q   <= 1'b0;
      start_q <= 1'b0;
      end_q   <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      for (int c = 0; c < 3; c++) begin
        wptr_q[c] <= wptr_d[c];
        rptr_q[c] <= rptr_d[c];
        cnt_q[c]  <= cnt_d[c];
      end
      ovf_q   <= ovf_d;
      rr_q    <= rr_d;
      chid_q  <= chid_d;
      len_q   <= len_d;
      wcnt_q  <= wcnt_d;
      req_q   <= req_d;
      val_q   <= val_d;
      start_q <= start_d;
      end_q   <= end_d;
      data_q  <= data_d;
    end
  end

  assign fmt_req_o    = req_q;
  assign fmt_chid_o   = chid_q;
  assign fmt_length_o = len_q;
  assign fmt_val_o    = val_q;
  assign fmt_data_o   = data_q;
  assign fmt_start_o  = start_q;
  assign fmt_end_o    = end_q;
  assign ovf_o        = ovf_q;

endmodule
